// File: rtl/level_qualifier.sv
// -----------------------------------------------------------------------------
// level_qualifier
//
// Multi-channel level qualifier for configuration handshake pins (CCLK,
// MCU-ready, cable-detect). Each channel synchronises an asynchronous level,
// asserts a registered `ready` once the synchronised level has been high for
// HOLD_CYCLES consecutive clocks, and drops it either immediately
// (DROP_CYCLES = 0) or after DROP_CYCLES consecutive low samples.
//
// Parameters:
//   CLK_RATE     clock frequency in Hz, only used for the HOLD_CYCLES default
//   CHANNELS     number of independent channels (1..32)
//   SYNC_STAGES  synchroniser flops per channel (>= 2)
//   HOLD_CYCLES  consecutive high samples needed to assert ready (>= 1)
//   DROP_CYCLES  consecutive low samples needed to deassert ready (0 = at once)
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   in_raw      asynchronous level inputs, one per channel
//   ready       qualified level per channel (registered)
//   rise_pulse  one-cycle pulse in the first cycle ready reads 1
//   fall_pulse  one-cycle pulse in the first cycle ready reads 0
//   all_ready   AND of all ready bits
//
// Optional feature (macro LEVEL_QUALIFIER_DROP_CNT_EN):
//   clr_cnt     synchronous clear of all drop counts
//   drop_cnt    8-bit saturating fall_pulse count per channel, channel i at
//               bits [8i+7:8i]; a clear coinciding with a fall_pulse leaves 1
// -----------------------------------------------------------------------------
module level_qualifier #(
   parameter int CLK_RATE    = 50000000,
   parameter int CHANNELS    = 1,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = CLK_RATE / 50000,
   parameter int DROP_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CHANNELS-1:0]   in_raw,
`ifdef LEVEL_QUALIFIER_DROP_CNT_EN
   input  logic                  clr_cnt,
   output logic [CHANNELS*8-1:0] drop_cnt,
`endif
   output logic [CHANNELS-1:0]   ready,
   output logic [CHANNELS-1:0]   rise_pulse,
   output logic [CHANNELS-1:0]   fall_pulse,
   output logic                  all_ready
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_QUAL  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;
   localparam logic [1:0] ST_DROP  = 2'd3;

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int DROP_W = (DROP_CYCLES > 0) ? $clog2(DROP_CYCLES + 1) : 1;

   // Terminal counts: the transition happens on the sample that would make
   // the count reach HOLD_CYCLES / DROP_CYCLES, so the counters never wrap.
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [DROP_W-1:0] DROP_LAST =
      DROP_W'((DROP_CYCLES > 0) ? DROP_CYCLES - 1 : 0);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s;
      logic [1:0]             state_q;
      logic [1:0]             state_nx;
      logic [HOLD_W-1:0]      cnt_q;
      logic [DROP_W-1:0]      dcnt_q;
      logic                   ready_q;
      logic                   ready_nx;
      logic                   rise_q;
      logic                   fall_q;

      // Synchroniser: bit 0 samples the asynchronous pin, the last bit is the
      // only one the qualifier logic ever looks at.
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbour; blocking here would
      // collapse the chain into a single stage.
      always_ff @(posedge clk) begin
         if (rst) begin
            sync_q <= '0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_raw[i]};
         end
      end

      assign s = sync_q[SYNC_STAGES-1];

      // NOTE: the default assignment at the top of this block is what keeps
      // it purely combinational; any path that left state_nx unassigned
      // would infer a latch.
      always_comb begin
         state_nx = state_q;
         case (state_q)
            ST_IDLE: begin
               if (s) begin
                  state_nx = (HOLD_CYCLES == 1) ? ST_READY : ST_QUAL;
               end
            end
            ST_QUAL: begin
               if (!s) begin
                  state_nx = ST_IDLE;
               end else if (cnt_q == HOLD_LAST) begin
                  state_nx = ST_READY;
               end
            end
            ST_READY: begin
               if (!s) begin
                  state_nx = (DROP_CYCLES <= 1) ? ST_IDLE : ST_DROP;
               end
            end
            ST_DROP: begin
               if (s) begin
                  state_nx = ST_READY;
               end else if (dcnt_q == DROP_LAST) begin
                  state_nx = ST_IDLE;
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end

      // DROP still presents ready=1: the level is only considered gone once
      // the debounce window has fully elapsed.
      assign ready_nx = (state_nx == ST_READY) || (state_nx == ST_DROP);

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            state_q <= state_nx;
            // Hold count restarts at 1 on entry to QUAL (the entering sample
            // already counts) and is cleared in every other state.
            if (state_nx == ST_QUAL) begin
               cnt_q <= (state_q == ST_QUAL) ? cnt_q + HOLD_W'(1) : HOLD_W'(1);
            end else begin
               cnt_q <= '0;
            end
            ready_q <= ready_nx;
            // Edge pulses are computed from the next ready value so they line
            // up with the first cycle the new level is visible.
            rise_q  <= ready_nx & ~ready_q;
            fall_q  <= ~ready_nx & ready_q;
         end
      end

      // The drop counter only exists when there is a debounce window longer
      // than one sample; otherwise DROP is unreachable.
      if (DROP_CYCLES > 1) begin : g_drop
         always_ff @(posedge clk) begin
            if (rst) begin
               dcnt_q <= '0;
            end else if (state_nx == ST_DROP) begin
               dcnt_q <= (state_q == ST_DROP) ? dcnt_q + DROP_W'(1) : DROP_W'(1);
            end else begin
               dcnt_q <= '0;
            end
         end
      end else begin : g_no_drop
         assign dcnt_q = '0;
      end

      assign ready[i]      = ready_q;
      assign rise_pulse[i] = rise_q;
      assign fall_pulse[i] = fall_q;

`ifdef LEVEL_QUALIFIER_DROP_CNT_EN
      logic [7:0] fall_cnt_q;

      // Counts registered fall pulses; a clear in the same cycle as a pulse
      // keeps that pulse so no drop event is ever lost.
      always_ff @(posedge clk) begin
         if (rst) begin
            fall_cnt_q <= '0;
         end else if (clr_cnt) begin
            fall_cnt_q <= fall_q ? 8'd1 : 8'd0;
         end else if (fall_q && (fall_cnt_q != 8'hFF)) begin
            fall_cnt_q <= fall_cnt_q + 8'd1;
         end
      end

      assign drop_cnt[8*i +: 8] = fall_cnt_q;
`endif

   end : g_ch

   assign all_ready = &ready;

endmodule

// File: tb/tb_level_qualifier.sv
// -----------------------------------------------------------------------------
// tb_level_qualifier
//
// Self-checking bench for level_qualifier. Two instances share clk/rst:
//   dut_a : CHANNELS=4, SYNC_STAGES=2, HOLD_CYCLES=4, DROP_CYCLES=0
//   dut_b : CHANNELS=1, SYNC_STAGES=2, HOLD_CYCLES=4, DROP_CYCLES=3
// Expected outputs are derived from the latency rules
//   rise at edge k + SYNC-1 + HOLD, fall at edge k + SYNC-1 + max(DROP,1)
// where k is the first edge that samples the new raw level.
// Inputs are driven 1 time unit after a rising edge; outputs sampled there too.
// -----------------------------------------------------------------------------
module tb_level_qualifier;

   localparam int SYNC   = 2;
   localparam int HOLD   = 4;
   localparam int DROP_B = 3;
   // Latency from the sampling edge of a raw change to the ready change.
   localparam int LAT_RISE   = SYNC - 1 + HOLD;   // 5
   localparam int LAT_FALL_A = SYNC - 1 + 1;      // 2  (DROP=0)
   localparam int LAT_FALL_B = SYNC - 1 + DROP_B; // 4

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] raw_a;
   logic [0:0] raw_b;
   logic [3:0] rdy_a, rise_a, fall_a;
   logic       all_a;
   logic [0:0] rdy_b, rise_b, fall_b;
   logic       all_b;
`ifdef LEVEL_QUALIFIER_DROP_CNT_EN
   logic        clr_a, clr_b;
   logic [31:0] dcnt_a;
   logic [7:0]  dcnt_b;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [3:0] rdy_a;
      logic [3:0] rise_a;
      logic [3:0] fall_a;
      logic       all_a;
      logic       rdy_b;
      logic       rise_b;
      logic       fall_b;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   level_qualifier #(
      .CLK_RATE(50000000), .CHANNELS(4), .SYNC_STAGES(SYNC),
      .HOLD_CYCLES(HOLD), .DROP_CYCLES(0)
   ) dut_a (
      .clk(clk),
      .rst(rst),
      .in_raw(raw_a),
`ifdef LEVEL_QUALIFIER_DROP_CNT_EN
      .clr_cnt(clr_a),
      .drop_cnt(dcnt_a),
`endif
      .ready(rdy_a),
      .rise_pulse(rise_a),
      .fall_pulse(fall_a),
      .all_ready(all_a)
   );

   level_qualifier #(
      .CLK_RATE(50000000), .CHANNELS(1), .SYNC_STAGES(SYNC),
      .HOLD_CYCLES(HOLD), .DROP_CYCLES(DROP_B)
   ) dut_b (
      .clk(clk),
      .rst(rst),
      .in_raw(raw_b),
`ifdef LEVEL_QUALIFIER_DROP_CNT_EN
      .clr_cnt(clr_b),
      .drop_cnt(dcnt_b),
`endif
      .ready(rdy_b),
      .rise_pulse(rise_b),
      .fall_pulse(fall_b),
      .all_ready(all_b)
   );

   function automatic exp_t observe();
      exp_t o;
      o.rdy_a  = rdy_a;
      o.rise_a = rise_a;
      o.fall_a = fall_a;
      o.all_a  = all_a;
      o.rdy_b  = rdy_b[0];
      o.rise_b = rise_b[0];
      o.fall_b = fall_b[0];
      return o;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      raw_a = '0;
      raw_b = '0;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   // Reset state with all inputs high, then one released edge (still 0
   // because of synchroniser latency).
   task automatic test_reset();
      exp_t e, o;
      rst   = 1'b1;
      raw_a = 4'hF;
      raw_b = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         if (k == 4) rst = 1'b0;
         sb_q.push_back('0);
         tick();
         e = sb_q.pop_front();
         o = observe();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL reset edge %0d: got %h expected %h", k, o, e);
         end
      end
   endtask

   // Single channel: rise then immediate drop.
   task automatic test_basic();
      exp_t e, o;
      int rise_e, fall_e;
      rise_e = 1 + LAT_RISE;
      fall_e = 10 + LAT_FALL_A;
      do_reset();
      for (int k = 1; k <= 14; k++) begin
         raw_a = {3'b000, (k <= 9)};
         e = '0;
         e.rdy_a[0]  = (k >= rise_e) && (k < fall_e);
         e.rise_a[0] = (k == rise_e);
         e.fall_a[0] = (k == fall_e);
         sb_q.push_back(e);
         tick();
         e = sb_q.pop_front();
         o = observe();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL basic edge %0d: got %h expected %h", k, o, e);
         end
      end
   endtask

   // High for 3, low for 1, then high: only the last run of highs qualifies.
   task automatic test_high_glitch();
      exp_t e, o;
      int rise_e;
      rise_e = 5 + LAT_RISE;
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         raw_a = {3'b000, (k <= 3) || (k >= 5)};
         e = '0;
         e.rdy_a[0]  = (k >= rise_e);
         e.rise_a[0] = (k == rise_e);
         sb_q.push_back(e);
         tick();
         e = sb_q.pop_front();
         o = observe();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL high_glitch edge %0d: got %h expected %h", k, o, e);
         end
      end
   endtask

   // Same waveform on both instances: a 2-cycle low glitch drops dut_a
   // (DROP=0) but is absorbed by dut_b (DROP=3); a long low drops both.
   task automatic test_drop_debounce();
      exp_t e, o;
      logic lvl;
      do_reset();
      for (int k = 1; k <= 22; k++) begin
         lvl   = (k <= 8) || (k >= 11 && k <= 15);
         raw_a = {3'b000, lvl};
         raw_b = lvl;
         e = '0;
         e.rdy_a[0]  = (k >= 1 + LAT_RISE && k < 9 + LAT_FALL_A) ||
                       (k >= 11 + LAT_RISE && k < 16 + LAT_FALL_A);
         e.rise_a[0] = (k == 1 + LAT_RISE) || (k == 11 + LAT_RISE);
         e.fall_a[0] = (k == 9 + LAT_FALL_A) || (k == 16 + LAT_FALL_A);
         e.rdy_b     = (k >= 1 + LAT_RISE) && (k < 16 + LAT_FALL_B);
         e.rise_b    = (k == 1 + LAT_RISE);
         e.fall_b    = (k == 16 + LAT_FALL_B);
         sb_q.push_back(e);
         tick();
         e = sb_q.pop_front();
         o = observe();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL drop_debounce edge %0d: got %h expected %h", k, o, e);
         end
      end
   endtask

   // Staggered qualification on four channels, then channel 2 drops.
   task automatic test_channels();
      exp_t e, o;
      int start[4];
      int drop_k;
      start  = '{1, 3, 7, 4};
      drop_k = 15;
      do_reset();
      for (int k = 1; k <= 19; k++) begin
         e = '0;
         for (int c = 0; c < 4; c++) begin
            raw_a[c]    = (k >= start[c]) && !(c == 2 && k >= drop_k);
            e.rdy_a[c]  = (k >= start[c] + LAT_RISE) &&
                          !(c == 2 && k >= drop_k + LAT_FALL_A);
            e.rise_a[c] = (k == start[c] + LAT_RISE);
            e.fall_a[c] = (c == 2) && (k == drop_k + LAT_FALL_A);
         end
         e.all_a = &e.rdy_a;
         sb_q.push_back(e);
         tick();
         e = sb_q.pop_front();
         o = observe();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL channels edge %0d: got %h expected %h", k, o, e);
         end
      end
   endtask

   // Reset at edge 6 (hold count 3 of 4) and at edge 14 (READY); raw stays
   // high so each release restarts the full latency, and no fall pulse appears.
   task automatic test_reset_mid();
      exp_t e, o;
      logic r;
      do_reset();
      raw_a = 4'b0001;
      raw_b = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         rst = (k == 6) || (k == 14);
         r   = (k >= 7 + LAT_RISE && k < 14) || (k >= 15 + LAT_RISE);
         e = '0;
         e.rdy_a[0]  = r;
         e.rise_a[0] = (k == 7 + LAT_RISE) || (k == 15 + LAT_RISE);
         e.rdy_b     = r;
         e.rise_b    = e.rise_a[0];
         sb_q.push_back(e);
         tick();
         e = sb_q.pop_front();
         o = observe();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL reset_mid edge %0d: got %h expected %h", k, o, e);
         end
      end
      rst = 1'b0;
   endtask

`ifdef LEVEL_QUALIFIER_DROP_CNT_EN
   task automatic test_drop_cnt();
      logic [31:0] q32[$];
      logic [31:0] exp32;
      int          n_fall;
      n_fall = 0;
      clr_a  = 1'b0;
      clr_b  = 1'b0;
      do_reset();
      for (int ev = 1; ev <= 300; ev++) begin
         raw_a[0] = 1'b1;
         repeat (7) tick();
         raw_a[0] = 1'b0;
         for (int j = 1; j <= 4; j++) begin
            tick();
            if (fall_a[0]) n_fall++;
         end
         if (ev == 100 || ev == 300) begin
            q32.push_back((ev > 255) ? 32'd255 : 32'(ev));
            exp32 = q32.pop_front();
            n_cmp++;
            if (dcnt_a !== exp32) begin
               n_bad++;
               $display("FAIL drop_cnt after %0d drops: got %0d expected %0d",
                        ev, dcnt_a, exp32);
            end
         end
      end
      n_cmp++;
      if (n_fall != 300) begin
         n_bad++;
         $display("FAIL fall_pulse count: got %0d expected 300", n_fall);
      end
      // Clear in the same cycle as a fall pulse keeps that pulse.
      raw_a[0] = 1'b1;
      repeat (7) tick();
      raw_a[0] = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         clr_a = (j == 4);
         tick();
      end
      clr_a = 1'b0;
      q32.push_back(32'd1);
      exp32 = q32.pop_front();
      n_cmp++;
      if (dcnt_a !== exp32) begin
         n_bad++;
         $display("FAIL drop_cnt clr+fall: got %0d expected %0d", dcnt_a, exp32);
      end
      n_cmp++;
      if (dcnt_b !== 8'd0) begin
         n_bad++;
         $display("FAIL drop_cnt idle channel: got %0d expected 0", dcnt_b);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      q32.push_back(32'd0);
      exp32 = q32.pop_front();
      n_cmp++;
      if (dcnt_a !== exp32) begin
         n_bad++;
         $display("FAIL drop_cnt reset: got %0d expected %0d", dcnt_a, exp32);
      end
   endtask
`endif

   initial begin
      rst   = 1'b1;
      raw_a = '0;
      raw_b = '0;
`ifdef LEVEL_QUALIFIER_DROP_CNT_EN
      clr_a = 1'b0;
      clr_b = 1'b0;
`endif
      #1;
      test_reset();
      test_basic();
      test_high_glitch();
      test_drop_debounce();
      test_channels();
      test_reset_mid();
`ifdef LEVEL_QUALIFIER_DROP_CNT_EN
      test_drop_cnt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
